// File: rtl/multipath_spy_delay_monitor.sv
// Multi-channel delay-chain spy monitor: launches a word into CHANNELS non-inverting
// NAND chains, captures it after a programmable delay and flags any bit that changed.
module multipath_spy_delay_monitor #(
    parameter int CHANNELS       = 4,
    parameter int STAGES         = 16,
    parameter int CAPTURE_CYCLES = 2,
    parameter int TRIG_COUNT     = 8,
    parameter int PAYLOAD_MODE   = 0,
    parameter int TARGET_CH      = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                VCC,
    input  logic                GND,
    input  logic                START,
    input  logic [CHANNELS-1:0] LAUNCH_VAL,
    input  logic                HT_IN1,
    input  logic                HT_IN2,
    output logic [CHANNELS-1:0] CH_OUT,
    output logic [CHANNELS-1:0] CAPTURE,
    output logic [CHANNELS-1:0] MISMATCH,
    output logic                BUSY,
    output logic                DONE,
    output logic                HT_ARMED,
    output logic [15:0]         RUN_COUNT
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, FIN} state_t;

    localparam logic [7:0]  WAIT_INIT = 8'(CAPTURE_CYCLES - 1);
    localparam logic [15:0] TRIG_LAST = 16'(TRIG_COUNT - 1);

    state_t              state;
    logic [CHANNELS-1:0] launch_reg;
    logic [7:0]          wait_cnt;
    logic [15:0]         trig_cnt;
    logic [15:0]         run_count;
    logic                t_q;
    logic                ht_armed;
    logic                trig;

    function automatic logic payload_fn(input logic x, input logic vcc, input logic gnd);
        return (PAYLOAD_MODE == 0) ? (x ^ vcc) : (x & gnd);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Delay chains: two NAND-with-VCC gates per stage, so every stage output equals its input
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        for (genvar s = 0; s < STAGES; s++) begin : stg
            (* keep *) logic din;
            (* keep *) logic mid;
            (* keep *) logic dout;
            if (s == 0) begin : g_head
                assign din = launch_reg[i];
            end else begin : g_link
                assign din = stg[s-1].dout;
            end
            assign mid = ~(din & VCC);
            if (i == TARGET_CH && s == STAGES/2 - 1) begin : g_payload
                assign dout = ht_armed ? payload_fn(~(mid & VCC), VCC, GND) : ~(mid & VCC);
            end else begin : g_plain
                assign dout = ~(mid & VCC);
            end
        end
        assign CH_OUT[i] = stg[STAGES-1].dout;
    end

    assign trig      = HT_IN1 & HT_IN2;
    assign HT_ARMED  = ht_armed;
    assign RUN_COUNT = run_count;

    // Trigger: counts rising edges of HT_IN1&HT_IN2, arms on the TRIG_COUNT-th and then freezes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            t_q      <= 1'b0;
            trig_cnt <= 16'd0;
            ht_armed <= 1'b0;
        end else begin
            t_q <= trig;
            if (trig && !t_q && !ht_armed) begin
                trig_cnt <= trig_cnt + 16'd1;
                if (trig_cnt == TRIG_LAST)
                    ht_armed <= 1'b1;
            end
        end
    end

    // Launch/capture FSM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            launch_reg <= '0;
            wait_cnt   <= 8'd0;
            CAPTURE    <= '0;
            MISMATCH   <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            run_count  <= 16'd0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        launch_reg <= LAUNCH_VAL;
                        wait_cnt   <= WAIT_INIT;
                        state      <= WAIT;
                        BUSY       <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 8'd0)
                        state <= CAPT;
                    else
                        wait_cnt <= wait_cnt - 8'd1;
                end
                CAPT: begin
                    CAPTURE  <= CH_OUT;
                    MISMATCH <= CH_OUT ^ launch_reg;
                    DONE     <= 1'b1;
                    state    <= FIN;
                end
                FIN: begin
                    run_count <= sat_inc(run_count);
                    state     <= IDLE;
                    BUSY      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multipath_spy_delay_monitor.sv
// Bench for multipath_spy_delay_monitor: one instance per payload mode, shared stimulus,
// expected capture/mismatch words queued at launch and compared when DONE appears.
module tb_multipath_spy_delay_monitor;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VCC = 1'b1;
    logic        GND = 1'b0;
    logic        START;
    logic [3:0]  LAUNCH_VAL;
    logic        HT_IN1, HT_IN2;

    logic [3:0]  ch0, cap0, mis0, ch1, cap1, mis1;
    logic        busy0, done0, arm0, busy1, done1, arm1;
    logic [15:0] rc0, rc1;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    bit          armed_m = 0;
    logic [15:0] run_m = 16'd0;
    logic [15:0] sb[$];

    always #5 CLK = ~CLK;

    multipath_spy_delay_monitor #(.PAYLOAD_MODE(0)) dut0 (
        .CLK(CLK), .RST(RST), .VCC(VCC), .GND(GND), .START(START), .LAUNCH_VAL(LAUNCH_VAL),
        .HT_IN1(HT_IN1), .HT_IN2(HT_IN2), .CH_OUT(ch0), .CAPTURE(cap0), .MISMATCH(mis0),
        .BUSY(busy0), .DONE(done0), .HT_ARMED(arm0), .RUN_COUNT(rc0));

    multipath_spy_delay_monitor #(.PAYLOAD_MODE(1)) dut1 (
        .CLK(CLK), .RST(RST), .VCC(VCC), .GND(GND), .START(START), .LAUNCH_VAL(LAUNCH_VAL),
        .HT_IN1(HT_IN1), .HT_IN2(HT_IN2), .CH_OUT(ch1), .CAPTURE(cap1), .MISMATCH(mis1),
        .BUSY(busy1), .DONE(done1), .HT_ARMED(arm1), .RUN_COUNT(rc1));

    always @(posedge CLK) if (done0) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] exp_ch(input logic [3:0] lv, input int mode);
        if (!armed_m) return lv;
        return (mode == 0) ? (lv ^ 4'b0001) : (lv & 4'b1110);
    endfunction

    task automatic pulse_trig();
        @(negedge CLK); HT_IN1 = 1'b1; HT_IN2 = 1'b1;
        @(negedge CLK); HT_IN1 = 1'b0; HT_IN2 = 1'b0;
    endtask

    task automatic run(input logic [3:0] lv);
        logic [15:0] e;
        int lat;
        bit seen;
        sb.push_back({exp_ch(lv, 0), exp_ch(lv, 0) ^ lv, exp_ch(lv, 1), exp_ch(lv, 1) ^ lv});
        @(negedge CLK); LAUNCH_VAL = lv; START = 1'b1;
        @(negedge CLK); START = 1'b0;
        chk("ch_out_m0", 32'(ch0), 32'(exp_ch(lv, 0)));
        chk("ch_out_m1", 32'(ch1), 32'(exp_ch(lv, 1)));
        lat = 1;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            if (done0) begin
                seen = 1;
                break;
            end
            @(negedge CLK);
            lat++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_latency", 32'(lat), 32'd4);
        e = sb.pop_front();
        chk("capture_m0", 32'(cap0), 32'(e[15:12]));
        chk("mismatch_m0", 32'(mis0), 32'(e[11:8]));
        chk("capture_m1", 32'(cap1), 32'(e[7:4]));
        chk("mismatch_m1", 32'(mis1), 32'(e[3:0]));
        @(negedge CLK);
        chk("done_one_cycle", 32'(done0), 32'd0);
        if (run_m != 16'hFFFF) run_m = run_m + 16'd1;
        chk("run_count_m0", 32'(rc0), 32'(run_m));
        chk("run_count_m1", 32'(rc1), 32'(run_m));
    endtask

    initial begin
        int d0;
        RST = 1'b1; START = 1'b0; LAUNCH_VAL = 4'd0; HT_IN1 = 1'b0; HT_IN2 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ch_out", 32'(ch0), 32'd0);
        chk("rst_capture", 32'(cap0), 32'd0);
        chk("rst_mismatch", 32'(mis0), 32'd0);
        chk("rst_busy_done", 32'({busy0, done0}), 32'd0);
        chk("rst_armed", 32'(arm0), 32'd0);
        chk("rst_run_count", 32'(rc0), 32'd0);
        RST = 1'b0;

        // Reset in WAIT after partial triggering
        repeat (3) pulse_trig();
        @(negedge CLK); LAUNCH_VAL = 4'b0110; START = 1'b1;
        @(negedge CLK); START = 1'b0;
        chk("midrun_busy_before", 32'(busy0), 32'd1);
        d0 = done_cnt;
        #2 RST = 1'b1;
        #1;
        chk("midrun_busy", 32'(busy0), 32'd0);
        chk("midrun_armed", 32'(arm0), 32'd0);
        chk("midrun_trig_cnt", 32'(dut0.trig_cnt), 32'd0);
        @(negedge CLK); RST = 1'b0;
        repeat (8) @(negedge CLK);
        chk("midrun_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrun_run_count", 32'(rc0), 32'd0);

        // Clean run, trojan not armed
        run(4'b1010);

        // Arming
        repeat (7) pulse_trig();
        chk("armed_after7_m0", 32'(arm0), 32'd0);
        chk("armed_after7_m1", 32'(arm1), 32'd0);
        pulse_trig();
        armed_m = 1;
        chk("armed_after8_m0", 32'(arm0), 32'd1);
        chk("armed_after8_m1", 32'(arm1), 32'd1);
        @(negedge CLK); HT_IN1 = 1'b1; HT_IN2 = 1'b1;
        repeat (5) @(negedge CLK);
        chk("trig_cnt_hold", 32'(dut0.trig_cnt), 32'd8);
        chk("armed_sticky", 32'(arm0), 32'd1);
        HT_IN1 = 1'b0; HT_IN2 = 1'b0;

        // Payload runs
        run(4'b1111);
        run(4'b0000);
        run(4'b0001);

        // START during WAIT is ignored
        @(negedge CLK); LAUNCH_VAL = 4'b0011; START = 1'b1;
        @(negedge CLK); START = 1'b0;
        d0 = done_cnt;
        @(negedge CLK); LAUNCH_VAL = 4'b1100; START = 1'b1;
        @(negedge CLK); START = 1'b0;
        repeat (8) @(negedge CLK);
        run_m = run_m + 16'd1;
        chk("interlock_one_done", 32'(done_cnt - d0), 32'd1);
        chk("interlock_capture", 32'(cap0), 32'(exp_ch(4'b0011, 0)));
        chk("interlock_run_count", 32'(rc0), 32'(run_m));

        // Saturation
        @(negedge CLK);
        force dut0.run_count = 16'hFFFE;
        force dut1.run_count = 16'hFFFE;
        @(negedge CLK);
        release dut0.run_count;
        release dut1.run_count;
        run_m = 16'hFFFE;
        run(4'b0101);
        run(4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
